// File: rtl/gpio_bank_if.sv
// gpio_bank_if
//   CPU IO bus slice seen by one GPIO bank (the part of the bus behind the
//   0x03000000 top-level address decode).
//
//   IOAdr   [4:0]   byte address inside the bank ([4:2] = register select)
//   WriteIO [31:0]  write data
//   IOWrite         write strobe, sampled on the rising clock edge
//   ReadIO  [31:0]  read data, combinational from IOAdr
//
//   master : CPU / bus side (drives address, data, strobe)
//   slave  : GPIO bank side (returns read data)
interface gpio_bank_if;
   logic [4:0]  IOAdr;
   logic [31:0] WriteIO;
   logic        IOWrite;
   logic [31:0] ReadIO;

   modport master (
      output IOAdr,
      output WriteIO,
      output IOWrite,
      input  ReadIO
   );

   modport slave (
      input  IOAdr,
      input  WriteIO,
      input  IOWrite,
      output ReadIO
   );
endinterface

// File: rtl/gpio_bank.sv
// gpio_bank
//   Parametrised memory-mapped GPIO peripheral. Provides per-pin output data
//   and direction registers, atomic SET/CLR writes, synchronised input
//   sampling and edge-triggered interrupts with write-1-to-clear status.
//   Pad tristating is done outside: this block only drives separate out and
//   output-enable vectors.
//
//   Register map (byte offset):
//     0x00 DATA_OUT   RW
//     0x04 DIR        RW   (1 = drive pin)
//     0x08 DATA_IN    RO   (synchronised pin values, all pins)
//     0x0C SET        WO   DATA_OUT |= data, reads 0
//     0x10 CLR        WO   DATA_OUT &= ~data, reads 0
//     0x14 IRQ_EN     RW
//     0x18 IRQ_STATUS R/W1C
//     0x1C IRQ_POL    RW   (0 = rising edge, 1 = falling edge)
//   Bits [31:WIDTH] of every register read 0 and ignore writes.
//
//   Parameters:
//     WIDTH           number of pins (1..32)
//     SYNC_STAGES     synchroniser flops per pin (2..4)
//     DEBOUNCE_CYCLES stable-sample count before an input is accepted
//                     (2..65535), only used when GPIO_DEBOUNCE_EN is defined
//
//   Optional feature macro:
//     GPIO_DEBOUNCE_EN  adds a per-pin debounce filter after the synchroniser;
//                       DATA_IN and edge detection then use the filtered value.
//
//   Ports:
//     clk       system clock, rising edge
//     reset     asynchronous active-low reset
//     bus       IO bus slave (IOAdr / WriteIO / IOWrite / ReadIO)
//     gpio_in   asynchronous pad inputs
//     gpio_out  registered output values (DATA_OUT)
//     gpio_oe   registered output enables (DIR)
//     irq       interrupt request, |(IRQ_STATUS & IRQ_EN)
module gpio_bank #(
   parameter int WIDTH           = 28,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   gpio_bank_if.slave        bus,
   input  logic [WIDTH-1:0]  gpio_in,
   output logic [WIDTH-1:0]  gpio_out,
   output logic [WIDTH-1:0]  gpio_oe,
   output logic              irq
);

   // ------------------------------------------------------------------
   // Elaboration-time parameter range checks
   // ------------------------------------------------------------------
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("gpio_bank: WIDTH must be in 1..32");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("gpio_bank: SYNC_STAGES must be in 2..4");
   end
   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
      $error("gpio_bank: DEBOUNCE_CYCLES must be in 2..65535");
   end

   // ------------------------------------------------------------------
   // Register select
   // ------------------------------------------------------------------
   typedef enum logic [2:0] {
      REG_DATA_OUT   = 3'd0,
      REG_DIR        = 3'd1,
      REG_DATA_IN    = 3'd2,
      REG_SET        = 3'd3,
      REG_CLR        = 3'd4,
      REG_IRQ_EN     = 3'd5,
      REG_IRQ_STATUS = 3'd6,
      REG_IRQ_POL    = 3'd7
   } reg_sel_t;

   reg_sel_t         reg_sel;
   logic [WIDTH-1:0] wdata;

   assign reg_sel = reg_sel_t'(bus.IOAdr[4:2]);
   assign wdata   = bus.WriteIO[WIDTH-1:0];

   // Byte-lane bits of the address and the write-data bits above WIDTH
   // carry no meaning for this block.
   logic unused_bits;
   assign unused_bits = &{1'b0, bus.IOAdr[1:0], bus.WriteIO};

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] data_out_reg,   data_out_next;
   logic [WIDTH-1:0] dir_reg;
   logic [WIDTH-1:0] irq_en_reg;
   logic [WIDTH-1:0] irq_status_reg, irq_status_next;
   logic [WIDTH-1:0] irq_pol_reg;
   logic [WIDTH-1:0] prev_in_reg;

   logic [WIDTH-1:0] sync_in;   // synchroniser output
   logic [WIDTH-1:0] filt_in;   // value seen by DATA_IN and edge detect
   logic [WIDTH-1:0] edge_ev;   // per-pin event of the selected polarity

   // ------------------------------------------------------------------
   // Write decode
   // ------------------------------------------------------------------
   logic wr_data_out, wr_dir, wr_set, wr_clr, wr_irq_en, wr_w1c, wr_irq_pol;

   always_comb begin
      wr_data_out = 1'b0;
      wr_dir      = 1'b0;
      wr_set      = 1'b0;
      wr_clr      = 1'b0;
      wr_irq_en   = 1'b0;
      wr_w1c      = 1'b0;
      wr_irq_pol  = 1'b0;
      if (bus.IOWrite) begin
         case (reg_sel)
            REG_DATA_OUT:   wr_data_out = 1'b1;
            REG_DIR:        wr_dir      = 1'b1;
            REG_SET:        wr_set      = 1'b1;
            REG_CLR:        wr_clr      = 1'b1;
            REG_IRQ_EN:     wr_irq_en   = 1'b1;
            REG_IRQ_STATUS: wr_w1c      = 1'b1;
            REG_IRQ_POL:    wr_irq_pol  = 1'b1;
            default:        ;   // DATA_IN is read-only
         endcase
      end
   end

   always_comb begin
      data_out_next = data_out_reg;
      if (wr_data_out) data_out_next = wdata;
      if (wr_set)      data_out_next = data_out_reg | wdata;
      if (wr_clr)      data_out_next = data_out_reg & ~wdata;
   end

   // ------------------------------------------------------------------
   // Input synchroniser: one shift chain per pin, stage 0 faces the pad.
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            chain_reg <= '0;
         end else begin
            chain_reg <= {chain_reg[SYNC_STAGES-2:0], gpio_in[gi]};
         end
      end

      assign sync_in[gi] = chain_reg[SYNC_STAGES-1];
   end

   // ------------------------------------------------------------------
   // Optional debounce filter
   // ------------------------------------------------------------------
`ifdef GPIO_DEBOUNCE_EN
   localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);

   // The counter runs only while sync_in disagrees with the accepted value.
   // Any return to the accepted value restarts it, so a new level is taken
   // only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_deb
      logic [15:0] cnt_reg;
      logic        deb_reg;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cnt_reg <= '0;
            deb_reg <= 1'b0;
         end else if (sync_in[gi] == deb_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == DEB_LAST) begin
            deb_reg <= sync_in[gi];
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_reg + 16'd1;
         end
      end

      assign filt_in[gi] = deb_reg;
   end
`else
   assign filt_in = sync_in;
`endif

   // ------------------------------------------------------------------
   // Edge detect and interrupt status
   // ------------------------------------------------------------------
   // Only transitions of filt_in produce events; a polarity change alone
   // cannot, because prev_in_reg and filt_in still agree.
   assign edge_ev = ( irq_pol_reg &  prev_in_reg & ~filt_in)
                  | (~irq_pol_reg & ~prev_in_reg &  filt_in);

   // New events are ORed in after the W1C mask, so a set wins over a clear
   // hitting the same bit. Events on disabled pins are dropped outright.
   always_comb begin
      irq_status_next = irq_status_reg;
      if (wr_w1c) irq_status_next = irq_status_reg & ~wdata;
      irq_status_next = irq_status_next | (edge_ev & irq_en_reg);
   end

   // ------------------------------------------------------------------
   // Register file
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out_reg   <= '0;
         dir_reg        <= '0;
         irq_en_reg     <= '0;
         irq_status_reg <= '0;
         irq_pol_reg    <= '0;
         prev_in_reg    <= '0;
      end else begin
         data_out_reg   <= data_out_next;
         irq_status_reg <= irq_status_next;
         prev_in_reg    <= filt_in;
         if (wr_dir)     dir_reg     <= wdata;
         if (wr_irq_en)  irq_en_reg  <= wdata;
         if (wr_irq_pol) irq_pol_reg <= wdata;
      end
   end

   // ------------------------------------------------------------------
   // Outputs and read mux
   // ------------------------------------------------------------------
   function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
      logic [31:0] r;
      r = '0;
      r[WIDTH-1:0] = v;
      return r;
   endfunction

   assign gpio_out = data_out_reg;
   assign gpio_oe  = dir_reg;
   assign irq      = |(irq_status_reg & irq_en_reg);

   logic [WIDTH-1:0] read_data;

   always_comb begin
      read_data = '0;
      case (reg_sel)
         REG_DATA_OUT:   read_data = data_out_reg;
         REG_DIR:        read_data = dir_reg;
         REG_DATA_IN:    read_data = filt_in;
         REG_IRQ_EN:     read_data = irq_en_reg;
         REG_IRQ_STATUS: read_data = irq_status_reg;
         REG_IRQ_POL:    read_data = irq_pol_reg;
         default:        read_data = '0;   // SET / CLR are write-only
      endcase
   end

   assign bus.ReadIO = zext(read_data);

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank
//   Directed self-checking bench for gpio_bank (WIDTH = 28, SYNC_STAGES = 2,
//   DEBOUNCE_CYCLES = 16). Inputs are driven and outputs sampled on the
//   falling clock edge. Define GPIO_DEBOUNCE_EN to exercise the debounce build.
module tb_gpio_bank;
   localparam int WIDTH           = 28;
   localparam int SYNC_STAGES     = 2;
   localparam int DEBOUNCE_CYCLES = 16;
`ifdef GPIO_DEBOUNCE_EN
   localparam int IN_LAT = SYNC_STAGES + DEBOUNCE_CYCLES;
`else
   localparam int IN_LAT = SYNC_STAGES;
`endif
   localparam int SETTLE = IN_LAT + 4;

   localparam logic [4:0] A_DATA_OUT   = 5'h00;
   localparam logic [4:0] A_DIR        = 5'h04;
   localparam logic [4:0] A_DATA_IN    = 5'h08;
   localparam logic [4:0] A_SET        = 5'h0C;
   localparam logic [4:0] A_CLR        = 5'h10;
   localparam logic [4:0] A_IRQ_EN     = 5'h14;
   localparam logic [4:0] A_IRQ_STATUS = 5'h18;
   localparam logic [4:0] A_IRQ_POL    = 5'h1C;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] gpio_in;
   logic [WIDTH-1:0] gpio_out;
   logic [WIDTH-1:0] gpio_oe;
   logic             irq;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   gpio_bank_if bus_if ();

   gpio_bank #(
      .WIDTH           (WIDTH),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus_if),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .gpio_oe  (gpio_oe),
      .irq      (irq)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = 0x%08h", tag, got);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
      bus_if.IOAdr   = addr;
      bus_if.WriteIO = data;
      bus_if.IOWrite = 1'b1;
      tick();
      bus_if.IOWrite = 1'b0;
   endtask

   task automatic bus_read(input logic [4:0] addr, output logic [31:0] data);
      bus_if.IOAdr = addr;
      #1;
      data = bus_if.ReadIO;
   endtask

   task automatic check_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
      logic [31:0] rd;
      bus_read(addr, rd);
      check(tag, rd, exp);
   endtask

   initial begin
      #200_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [WIDTH-1:0] pins;

      // ---------------- reset with random pads ----------------
      reset          = 1'b0;
      pins           = WIDTH'($urandom);
      gpio_in        = pins;
      bus_if.IOAdr   = '0;
      bus_if.WriteIO = '0;
      bus_if.IOWrite = 1'b0;
      repeat (3) tick();
      check("rst gpio_out", 32'(gpio_out), 32'h0);
      check("rst gpio_oe",  32'(gpio_oe),  32'h0);
      check("rst irq",      32'(irq),      32'h0);
      check_reg("rst DATA_OUT",   A_DATA_OUT,   32'h0);
      check_reg("rst DIR",        A_DIR,        32'h0);
      check_reg("rst DATA_IN",    A_DATA_IN,    32'h0);
      check_reg("rst IRQ_EN",     A_IRQ_EN,     32'h0);
      check_reg("rst IRQ_STATUS", A_IRQ_STATUS, 32'h0);
      check_reg("rst IRQ_POL",    A_IRQ_POL,    32'h0);

      tick();
      reset = 1'b1;
      repeat (SETTLE) tick();
      check_reg("post-rst DATA_IN",    A_DATA_IN,    32'(pins));
      check_reg("post-rst IRQ_STATUS", A_IRQ_STATUS, 32'h0);
      check("post-rst irq", 32'(irq), 32'h0);
      gpio_in = '0;
      repeat (SETTLE) tick();

      // ---------------- DATA_OUT / SET / CLR ----------------
      bus_write(A_DATA_OUT, 32'h0000_00F0);
      check("gpio_out after write", 32'(gpio_out), 32'h0000_00F0);
      bus_write(A_SET, 32'h0000_000F);
      check("gpio_out after SET", 32'(gpio_out), 32'h0000_00FF);
      bus_write(A_CLR, 32'h0000_0030);
      check("gpio_out after CLR", 32'(gpio_out), 32'h0000_00CF);
      check_reg("DATA_OUT readback", A_DATA_OUT, 32'h0000_00CF);
      check_reg("SET reads 0", A_SET, 32'h0);
      check_reg("CLR reads 0", A_CLR, 32'h0);
      bus_write(A_DATA_OUT, 32'hFFFF_FFFF);
      check_reg("DATA_OUT upper bits", A_DATA_OUT, 32'h0FFF_FFFF);

      // ---------------- DIR ----------------
      bus_write(A_DIR, 32'hFFFF_FFFF);
      check_reg("DIR readback", A_DIR, 32'h0FFF_FFFF);
      check("gpio_oe all ones", 32'(gpio_oe), 32'h0FFF_FFFF);
      bus_write(A_DIR, 32'h0000_00A5);
      check("gpio_oe pattern", 32'(gpio_oe), 32'h0000_00A5);

      // ---------------- rising edge on pin 0 ----------------
      bus_write(A_IRQ_POL, 32'h0);
      bus_write(A_IRQ_EN,  32'h1);
      gpio_in[0] = 1'b1;
      repeat (IN_LAT - 1) tick();
      bus_read(A_DATA_IN, rd);
      check("DATA_IN[0] before latency", rd & 32'h1, 32'h0);
      tick();
      bus_read(A_DATA_IN, rd);
      check("DATA_IN[0] at latency", rd & 32'h1, 32'h1);
      check("irq before status", 32'(irq), 32'h0);
      tick();
      check_reg("IRQ_STATUS pin0 rise", A_IRQ_STATUS, 32'h1);
      check("irq pin0 rise", 32'(irq), 32'h1);
      check_reg("IRQ_STATUS read no clear", A_IRQ_STATUS, 32'h1);
      bus_write(A_IRQ_STATUS, 32'h1);
      check("irq after W1C", 32'(irq), 32'h0);
      check_reg("IRQ_STATUS after W1C", A_IRQ_STATUS, 32'h0);

      // falling edge with rising polarity: no event
      gpio_in[0] = 1'b0;
      repeat (SETTLE) tick();
      check_reg("pin0 fall ignored", A_IRQ_STATUS, 32'h0);

      // IRQ_EN clear masks irq but keeps status
      gpio_in[0] = 1'b1;
      repeat (SETTLE) tick();
      check("irq pin0 second rise", 32'(irq), 32'h1);
      bus_write(A_IRQ_EN, 32'h0);
      check("irq masked", 32'(irq), 32'h0);
      check_reg("status kept when masked", A_IRQ_STATUS, 32'h1);
      bus_write(A_IRQ_STATUS, 32'h1);
      check_reg("status cleared", A_IRQ_STATUS, 32'h0);

      // ---------------- falling edge on pin 3 vs W1C ----------------
      gpio_in[3] = 1'b1;
      repeat (SETTLE) tick();
      bus_write(A_IRQ_POL, 32'h8);
      bus_write(A_IRQ_EN,  32'h8);
      check_reg("POL change no event", A_IRQ_STATUS, 32'h0);
      gpio_in[3] = 1'b0;
      repeat (SETTLE) tick();
      check_reg("pin3 fall sets", A_IRQ_STATUS, 32'h8);
      gpio_in[3] = 1'b1;
      repeat (SETTLE) tick();
      check_reg("pin3 rise ignored", A_IRQ_STATUS, 32'h8);
      gpio_in[3] = 1'b0;
      repeat (IN_LAT) tick();
      // the event is pending this cycle; the W1C lands on the same edge
      bus_write(A_IRQ_STATUS, 32'h8);
      check_reg("set wins over W1C", A_IRQ_STATUS, 32'h8);
      check("irq after set-wins", 32'(irq), 32'h1);
      bus_write(A_IRQ_STATUS, 32'h8);
      check_reg("pin3 W1C alone", A_IRQ_STATUS, 32'h0);
      bus_write(A_IRQ_POL, 32'h0);
      repeat (3) tick();
      check_reg("POL flip no event", A_IRQ_STATUS, 32'h0);

      // ---------------- events on disabled pin discarded ----------------
      bus_write(A_IRQ_EN, 32'h0);
      gpio_in[5] = 1'b1;
      repeat (SETTLE) tick();
      gpio_in[5] = 1'b0;
      repeat (SETTLE) tick();
      bus_write(A_IRQ_EN, 32'h20);
      repeat (3) tick();
      check_reg("disabled pin5 discarded", A_IRQ_STATUS, 32'h0);
      check("irq pin5 disabled", 32'(irq), 32'h0);

`ifdef GPIO_DEBOUNCE_EN
      // ---------------- debounce on pin 1 ----------------
      gpio_in[1] = 1'b1;
      repeat (10) tick();
      gpio_in[1] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         repeat (10) tick();
         bus_read(A_DATA_IN, rd);
         check("glitch filtered", rd & 32'h2, 32'h0);
      end
      gpio_in[1] = 1'b1;
      repeat (IN_LAT - 1) tick();
      bus_read(A_DATA_IN, rd);
      check("pulse not yet accepted", rd & 32'h2, 32'h0);
      tick();
      bus_read(A_DATA_IN, rd);
      check("pulse accepted", rd & 32'h2, 32'h2);
      repeat (20 - IN_LAT) tick();
      gpio_in[1] = 1'b0;
      repeat (SETTLE) tick();
`endif

      // ---------------- asynchronous reset mid-operation ----------------
      bus_write(A_DATA_OUT, 32'h55);
      bus_write(A_DIR,      32'h0F);
      bus_write(A_IRQ_EN,   32'h1);
      gpio_in[0] = 1'b0;
      repeat (SETTLE) tick();
      gpio_in[0] = 1'b1;
      repeat (SETTLE) tick();
      check("irq before reset", 32'(irq), 32'h1);
      gpio_in = WIDTH'(32'h0F1);
      #2;
      reset = 1'b0;
      #1;
      check("async rst gpio_out", 32'(gpio_out), 32'h0);
      check("async rst gpio_oe",  32'(gpio_oe),  32'h0);
      check("async rst irq",      32'(irq),      32'h0);
      tick();
      reset = 1'b1;
      repeat (SETTLE) tick();
      check_reg("after rst DATA_IN",    A_DATA_IN,    32'h0F1);
      check_reg("after rst IRQ_STATUS", A_IRQ_STATUS, 32'h0);
      check_reg("after rst IRQ_EN",     A_IRQ_EN,     32'h0);
      check("after rst irq", 32'(irq), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
- Parametrised memory-mapped GPIO peripheral; next generation of the fixed 28-pin GPIO block.
- Sits on the CPU IO bus (IOAdr/WriteIO/IOWrite/ReadIO) behind the top-level 0x03000000 address decode.
- Adds per-pin direction control, atomic set/clear writes, synchronised input sampling and edge-triggered interrupts with write-1-to-clear status.
- Pad tristating stays outside the block: it drives separate out and output-enable vectors.

Parameters:
WIDTH, 28, number of GPIO pins (1..32); register bits [31:WIDTH] read 0 and ignore writes
SYNC_STAGES, 2, input synchroniser flops per pin (2..4)
DEBOUNCE_CYCLES, 16, stable-sample count before an input is accepted; used only with GPIO_DEBOUNCE_EN (2..65535)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset; all state clears while low
IOAdr  input  5  byte address within bank; [4:2] selects register, [1:0] ignored
WriteIO  input  32  write data
IOWrite  input  1  write strobe, sampled on rising clk
ReadIO  output  32  read data, combinational from IOAdr
gpio_in  input  WIDTH  asynchronous pad inputs
gpio_out  output  WIDTH  registered output values (= DATA_OUT)
gpio_oe  output  WIDTH  registered output enables (= DIR, 1 = drive)
irq  output  1  interrupt request, |(IRQ_STATUS & IRQ_EN)

Behaviour:
- Register map (offset, access, meaning):
  - 0x00 DATA_OUT RW
  - 0x04 DIR RW
  - 0x08 DATA_IN RO (synchronised pin values, all pins regardless of DIR)
  - 0x0C SET WO: DATA_OUT |= WriteIO, reads 0
  - 0x10 CLR WO: DATA_OUT &= ~WriteIO, reads 0
  - 0x14 IRQ_EN RW
  - 0x18 IRQ_STATUS R/W1C
  - 0x1C IRQ_POL RW: 0 = rising edge, 1 = falling edge
- Reset (reset low, asynchronous): DATA_OUT, DIR, IRQ_EN, IRQ_STATUS, IRQ_POL, synchroniser chain and previous-sample register all 0. Hence gpio_out = 0, gpio_oe = 0, irq = 0, ReadIO decodes from zeroed registers.
- Writes: take effect on the clk edge where IOWrite = 1. gpio_out and gpio_oe change on that same edge.
- Reads: combinational, same cycle, no side effects. Reading IRQ_STATUS does not clear it.
- Input path:
  - gpio_in passes through SYNC_STAGES flops to give sync_in.
  - DATA_IN = sync_in, so a pin change is visible SYNC_STAGES cycles later.
  - prev_in is sync_in delayed one cycle.
- Edge detect, per bit:
  - ev = IRQ_POL ? (prev & ~sync) : (~prev & sync).
  - IRQ_STATUS[i] sets when ev[i] & IRQ_EN[i]. Events on disabled pins are discarded, never latched.
  - An edge on the pad sets status SYNC_STAGES+1 cycles after the change; irq follows in the same cycle as status (combinational from registers).
- IRQ_STATUS next-state = (status & ~w1c_mask) | (ev & IRQ_EN). If a W1C and a new event hit the same bit in the same cycle, set wins.
- Clearing IRQ_EN[i] masks irq but does not clear IRQ_STATUS[i].
- Changing IRQ_POL does not generate an event by itself; only sync transitions do.
- Reset asserted mid-operation clears state immediately. After release, pins held high do not raise status, because IRQ_EN = 0.

Optional Feature:
- GPIO_DEBOUNCE_EN defined:
  - Per-pin counter after the synchroniser. A new sync_in value replaces the debounced value only after it has been stable for DEBOUNCE_CYCLES consecutive cycles; any change restarts the count.
  - DATA_IN and edge detection use the debounced value. Added latency is DEBOUNCE_CYCLES cycles.
  - Counters reset to 0; debounced value resets to 0.
- Not defined: no counters; DATA_IN and edge detection use sync_in directly; DEBOUNCE_CYCLES is unused.

Test Plan:
- Reset low with random gpio_in -> gpio_out = 0, gpio_oe = 0, irq = 0, all reads 0 except DATA_IN after release.
- Write DATA_OUT = 0x0000_00F0; write SET 0x0F; write CLR 0x30 -> gpio_out = 0x0000_00CF, read DATA_OUT = 0xCF.
- Write DIR = 0xFFFF_FFFF with WIDTH = 28 -> read DIR = 0x0FFF_FFFF, gpio_oe = all ones.
- IRQ_EN = 0x1, IRQ_POL = 0, gpio_in[0] 0->1 at cycle t -> DATA_IN[0] = 1 at t+2; IRQ_STATUS = 0x1 and irq = 1 at t+3; write IRQ_STATUS 0x1 -> irq = 0 next cycle.
- IRQ_POL[3] = 1, IRQ_EN[3] = 1, falling edge on pin 3 in the same cycle as a W1C of bit 3 -> status bit 3 stays 1.
- IRQ_EN = 0, toggle gpio_in[5]; then set IRQ_EN[5] = 1 -> IRQ_STATUS stays 0, irq stays 0.
- With GPIO_DEBOUNCE_EN: a 10-cycle glitch on pin 1 (DEBOUNCE_CYCLES = 16) -> DATA_IN[1] unchanged; a 20-cycle pulse -> DATA_IN[1] = 1.
